axis_rr_packet_arbiter: RTL

- Shares one AXI4-Stream master port between NumSources AXI4-Stream slave requesters, typically several axis_traffic_gen-style sources feeding one DUT input.
- Round-robin, packet-atomic arbitration: a granted source keeps the port until its tlast beat is accepted.
- Registered single-entry output stage.
- Testbench/infrastructure block; single clock domain.

---
 rtl/axis_rr_packet_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/axis_rr_packet_arbiter.sv
// Round-robin, packet-atomic AXI4-Stream arbiter with a registered single-entry output stage.
// Optional per-source packet counters are enabled by defining AXIS_ARB_PKT_STATS_EN.
module axis_rr_packet_arbiter #(
  parameter int NumSources = 4,
  parameter int TDataWidth = 32,
  parameter int TidWidth   = 8,
  parameter int TdestWidth = 8,
  parameter int CntWidth   = 16
) (
  input  logic                                m_axis_aclk,
  input  logic                                m_axis_arstn,
  input  logic [NumSources*TDataWidth-1:0]    s_axis_tdata,
  input  logic [NumSources*TidWidth-1:0]      s_axis_tid,
  input  logic [NumSources*TdestWidth-1:0]    s_axis_tdest,
  input  logic [NumSources-1:0]               s_axis_tvalid,
  input  logic [NumSources-1:0]               s_axis_tlast,
  output logic [NumSources-1:0]               s_axis_tready,
  output logic [TDataWidth-1:0]               m_axis_tdata,
  output logic [TidWidth-1:0]                 m_axis_tid,
  output logic [TdestWidth-1:0]               m_axis_tdest,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  output logic [$clog2(NumSources)-1:0]       grant_idx,
  output logic                                grant_active,
  output logic [NumSources*CntWidth-1:0]      stat_pkt_count
);

  localparam int IdxWidth = $clog2(NumSources);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]            state;
  logic [IdxWidth-1:0]   rr_ptr;
  logic [IdxWidth-1:0]   next_idx;
  logic [IdxWidth-1:0]   cand;
  logic                  req_found;
  logic                  out_free;
  logic                  accept;
  logic                  accept_last;

  logic [TDataWidth-1:0] s_data [NumSources];
  logic [TidWidth-1:0]   s_id   [NumSources];
  logic [TdestWidth-1:0] s_dest [NumSources];

  for (genvar g = 0; g < NumSources; g++) begin : g_unpack
    assign s_data[g] = s_axis_tdata[g*TDataWidth +: TDataWidth];
    assign s_id[g]   = s_axis_tid[g*TidWidth +: TidWidth];
    assign s_dest[g] = s_axis_tdest[g*TdestWidth +: TdestWidth];
  end

  // First requester strictly after the last served source, wrapping around.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    req_found = 1'b0;
    next_idx  = '0;
    cand      = '0;
    for (int k = 1; k <= NumSources; k++) begin
      cand = IdxWidth'((int'(rr_ptr) + k) % NumSources);
      if (!req_found && s_axis_tvalid[cand]) begin
        req_found = 1'b1;
        next_idx  = cand;
      end
    end
  end

  assign grant_active = (state == GRANT);
  assign out_free     = !m_axis_tvalid || m_axis_tready;
  assign accept       = grant_active && out_free && s_axis_tvalid[grant_idx];
  assign accept_last  = accept && s_axis_tlast[grant_idx];

  always_comb begin
    s_axis_tready            = '0;
    s_axis_tready[grant_idx] = grant_active && out_free;
  end

  always_ff @(posedge m_axis_aclk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
    if (!m_axis_arstn) begin
      state     <= IDLE;
      rr_ptr    <= IdxWidth'(NumSources - 1);
      grant_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_found) begin
            grant_idx <= next_idx;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (accept_last) begin
            rr_ptr <= grant_idx;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: loads on accept, drains on downstream ready, holds under backpressure.
  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_arstn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= '0;
      m_axis_tdest  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_data[grant_idx];
      m_axis_tid    <= s_id[grant_idx];
      m_axis_tdest  <= s_dest[grant_idx];
      m_axis_tlast  <= s_axis_tlast[grant_idx];
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_ARB_PKT_STATS_EN
  logic [CntWidth-1:0] pkt_cnt [NumSources];

  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_arstn) begin
      // NOTE: the counter array is architectural state, so every entry is cleared on reset.
      for (int i = 0; i < NumSources; i++) pkt_cnt[i] <= '0;
    end else if (accept_last && (pkt_cnt[grant_idx] != '1)) begin
      pkt_cnt[grant_idx] <= pkt_cnt[grant_idx] + CntWidth'(1);
    end
  end

  for (genvar g = 0; g < NumSources; g++) begin : g_stat
    assign stat_pkt_count[g*CntWidth +: CntWidth] = pkt_cnt[g];
  end
`else
  assign stat_pkt_count = '0;
`endif

endmodule
